// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART transmitter; each grant sends {header, payload}, one start/done per byte.
// Grant to tx_start is 1 cycle; per-byte done timeout aborts the frame; no grant while the UART is active.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int IDX_W        = 2,
  parameter int TIMEOUT_CLKS = 60000,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_frame,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_err,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done
);

  typedef enum logic [2:0] {IDLE, SEND0, WAIT0, SEND1, WAIT1, FIN} state_t;

  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       payload;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [15:0]      pick_frame;
  logic [IDX_W-1:0] ptr_nxt;
  logic [N_REQ-1:0] grant_onehot;

  // Scan offsets high to low so the smallest offset from ptr is the one that sticks.
  always_comb begin
    logic [IDX_W:0] sum;
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (req[sum[IDX_W-1:0]]) begin
        pick     = sum[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_frame = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IDX_W'(i)) pick_frame = req_frame[16*i +: 16];
    end
  end

  always_comb begin
    logic [IDX_W:0] inc;
    inc     = {1'b0, grant_id} + (IDX_W+1)'(1);
    ptr_nxt = (inc >= NREQ_W) ? '0 : inc[IDX_W-1:0];
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_onehot[i] = (grant_id == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      ack      <= '0;
      tx_err   <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
      payload  <= 8'h00;
      cnt      <= '0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      tx_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          // A UART still draining a byte (e.g. after reset) blocks new grants.
          if (pick_vld && !tx_active) begin
            grant_id <= pick;
            payload  <= pick_frame[7:0];
            tx_byte  <= pick_frame[15:8];
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND0;
          end
        end
        SEND0: begin
          cnt   <= '0;
          state <= WAIT0;
        end
        WAIT0: begin
          if (tx_done) begin
            tx_byte  <= payload;
            tx_start <= 1'b1;
            state    <= SEND1;
          end else if (cnt == CNT_LAST) begin
            ack    <= grant_onehot;
            tx_err <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND1: begin
          cnt   <= '0;
          state <= WAIT1;
        end
        WAIT1: begin
          if (tx_done) begin
            ack   <= grant_onehot;
            state <= FIN;
          end else if (cnt == CNT_LAST) begin
            ack    <= grant_onehot;
            tx_err <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIN: begin
          ptr   <= ptr_nxt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle-stamped transaction model plus directed scenarios.
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int T = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [16*N-1:0] req_frame = {16'hC0DE, 16'hBEEF, 16'h1234, 16'hA55A};
  logic           tx_active = 1'b0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   ack;
  logic           tx_err, busy, tx_start;
  logic [1:0]     grant_id;
  logic [7:0]     tx_byte;

  uart_tx_scheduler #(.N_REQ(N), .IDX_W(2), .TIMEOUT_CLKS(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_frame(req_frame),
    .ack(ack), .tx_err(tx_err), .busy(busy), .grant_id(grant_id),
    .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- UART + requester stimulus ----------------
  int        ucnt = 0;
  int        u_len = 12;
  bit        u_hang = 1'b0;
  bit        auto_rearm = 1'b0;
  bit [N-1:0] raise_pend = '0;

  task automatic tick();
    @(posedge clk); #2;
    tx_done = 1'b0;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        tx_active = 1'b0;
        tx_done   = !u_hang;
      end
    end
    if (tx_start === 1'b1) begin
      ucnt      = u_len;
      tx_active = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        req[i]        = 1'b0;
        raise_pend[i] = auto_rearm;
      end else if (raise_pend[i]) begin
        req[i]        = 1'b1;
        raise_pend[i] = 1'b0;
      end
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int          cyc = 0;
  logic        p_reset = 1'b1, p_active = 1'b0, p_done = 1'b0;
  logic [N-1:0] p_req = '0;
  logic [16*N-1:0] p_frame = '0;
  bit          e_busy = 1'b0, e_start, e_ack, e_err;
  int          g = 0, s = 0, fin_at = -10, bidx = 0, m_ptr = 0;
  logic [15:0] mf = '0;
  logic [7:0]  e_byte = '0;
  logic [N-1:0] e_ackv;

  logic [7:0] byte_log[$];
  int         start_cyc[$];
  int         ack_log[$];
  int         ack_cyc[$];
  int         err_cnt = 0;

  function automatic int rr(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    cyc++;
    e_start = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    if (p_reset) begin
      e_busy = 1'b0; m_ptr = 0; g = 0; e_byte = 8'h00; fin_at = -10;
    end else if (!e_busy) begin
      if (p_req != '0 && !p_active) begin
        g = rr(m_ptr, p_req);
        mf = p_frame[16*g +: 16];
        e_busy = 1'b1; s = cyc; bidx = 0; fin_at = -10;
        e_start = 1'b1; e_byte = mf[15:8];
      end
    end else if (fin_at == cyc - 1) begin
      e_busy = 1'b0;
      m_ptr = (g + 1) % N;
    end else if (fin_at < 0 && cyc - 1 > s) begin
      if (p_done) begin
        if (bidx == 0) begin
          e_start = 1'b1; e_byte = mf[7:0]; s = cyc; bidx = 1;
        end else begin
          e_ack = 1'b1; fin_at = cyc;
        end
      end else if (cyc - 1 - s == T) begin
        e_ack = 1'b1; e_err = 1'b1; fin_at = cyc;
      end
    end
    e_ackv = e_ack ? (4'b0001 << g) : 4'b0000;

    chk("busy", busy, e_busy);
    chk("tx_start", tx_start, e_start);
    chk("tx_err", tx_err, e_err);
    chk("ack", ack, e_ackv);
    chk("tx_byte", tx_byte, e_byte);
    if (e_busy || p_reset) chk("grant_id", grant_id, g);

    if (tx_start === 1'b1) begin byte_log.push_back(tx_byte); start_cyc.push_back(cyc); end
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin ack_log.push_back(i); ack_cyc.push_back(cyc); end
    end
    if (tx_err === 1'b1) err_cnt++;

    p_reset = reset; p_req = req; p_active = tx_active; p_done = tx_done; p_frame = req_frame;
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_acks(input int n, input int budget);
    int b;
    b = budget;
    while (ack_log.size() < n && b > 0) begin tick(); b--; end
    chk("wait_ack", ack_log.size() >= n, 1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int b;
    b = budget;
    while (byte_log.size() < n && b > 0) begin tick(); b--; end
    chk("wait_start", byte_log.size() >= n, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, bs, ne;
    int exp2[5];
    exp2 = '{0, 1, 2, 3, 0};

    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_grant_id", grant_id, 0);
    reset = 1'b0;
    tick();

    // 1: single frame, one-cycle grant latency
    nb = ack_log.size(); bs = byte_log.size();
    req = 4'b0001;
    tick();
    chk("t1_latency_start", tx_start, 1);
    chk("t1_latency_byte", tx_byte, 8'hA5);
    wait_acks(nb + 1, 200);
    tick(); tick();
    chk("t1_busy_after", busy, 0);
    chk("t1_nstarts", byte_log.size() - bs, 2);
    chk("t1_byte0", byte_log[bs], 8'hA5);
    chk("t1_byte1", byte_log[bs+1], 8'h5A);
    chk("t1_ack_id", ack_log[nb], 0);

    // 2: all requesting, drop/re-raise after ack
    do_reset();
    nb = ack_log.size();
    auto_rearm = 1'b1;
    req = 4'b1111;
    wait_acks(nb + 5, 500);
    auto_rearm = 1'b0; raise_pend = '0; req = '0;
    for (int k = 0; k < 5; k++) chk("t2_order", ack_log[nb+k], exp2[k]);
    repeat (5) tick();
    chk("t2_idle", busy, 0);

    // 3: UART never completes byte 0
    nb = ack_log.size(); bs = byte_log.size(); ne = err_cnt;
    u_hang = 1'b1;
    req = 4'b0001;
    wait_acks(nb + 1, 200);
    repeat (3) tick();
    u_hang = 1'b0;
    chk("t3_ack_id", ack_log[nb], 0);
    chk("t3_err_pulses", err_cnt - ne, 1);
    chk("t3_nstarts", byte_log.size() - bs, 1);
    chk("t3_timeout_span", ack_cyc[nb] - start_cyc[bs], T + 1);

    // 4: tx_done lands on the terminal count
    nb = ack_log.size(); bs = byte_log.size(); ne = err_cnt;
    u_len = T;
    req = 4'b1000;
    wait_acks(nb + 1, 200);
    repeat (3) tick();
    u_len = 12;
    chk("t4_ack_id", ack_log[nb], 3);
    chk("t4_no_err", err_cnt - ne, 0);
    chk("t4_nstarts", byte_log.size() - bs, 2);
    chk("t4_byte0", byte_log[bs], 8'hC0);
    chk("t4_byte1", byte_log[bs+1], 8'hDE);
    chk("t4_byte1_gap", start_cyc[bs+1] - start_cyc[bs], T + 1);

    // 6: requester drops req while its first byte is in flight
    nb = ack_log.size(); bs = byte_log.size();
    req = 4'b0010;
    wait_starts(bs + 1, 50);
    req = '0;
    req_frame[31:16] = 16'hFFFF;
    wait_acks(nb + 1, 200);
    repeat (20) tick();
    req_frame[31:16] = 16'h1234;
    chk("t6_nacks", ack_log.size() - nb, 1);
    chk("t6_ack_id", ack_log[nb], 1);
    chk("t6_nstarts", byte_log.size() - bs, 2);
    chk("t6_byte0", byte_log[bs], 8'h12);
    chk("t6_byte1", byte_log[bs+1], 8'h34);

    // 5: reset during the second byte while the UART is still busy
    nb = ack_log.size(); bs = byte_log.size(); ne = err_cnt;
    u_len = 15;
    req = 4'b0001;
    wait_starts(bs + 2, 100);
    repeat (3) tick();
    reset = 1'b1;
    req = 4'b0100;
    tick(); tick();
    reset = 1'b0;
    wait_acks(nb + 1, 300);
    repeat (3) tick();
    chk("t5_nacks", ack_log.size() - nb, 1);
    chk("t5_ack_id", ack_log[nb], 2);
    chk("t5_no_err", err_cnt - ne, 0);
    chk("t5_nstarts", byte_log.size() - bs, 4);
    chk("t5_byte0", byte_log[bs+2], 8'hBE);
    chk("t5_byte1", byte_log[bs+3], 8'hEF);
    chk("t5_waits_uart", start_cyc[bs+2] - start_cyc[bs+1], 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
